// File: rtl/adc_frame_align_ctrl.sv
// Frame-lane calibration and lock controller for an LTC2195 LVDS receiver.
// Sweeps the input delay over all 32 taps, loads the centre of the widest
// stable eye, bitslips until the frame word matches, then watches for lock loss.
module adc_frame_align_ctrl #(
  parameter logic [3:0]  FRAME_PATTERN = 4'b0011,
  parameter int unsigned SETTLE_CYC    = 16,
  parameter int unsigned CHECK_CYC     = 64,
  parameter int unsigned SLIP_WAIT     = 8,
  parameter int unsigned MAX_SLIPS     = 8,
  parameter int unsigned MIN_EYE       = 4,
  parameter int unsigned LOSS_CYC      = 4
) (
  input  logic       DCO_2D,
  input  logic       rst_n_in,
  input  logic       start,
  input  logic       idelay_rdy,
  input  logic [3:0] fr_in,
  output logic [4:0] delay_val,
  output logic       bitslip,
  output logic       busy,
  output logic       aligned,
  output logic       align_err,
  output logic       lock_lost,
  output logic [4:0] eye_start,
  output logic [5:0] eye_len,
  output logic [3:0] slip_cnt
);

  localparam logic [6:0] SettleLast = 7'(SETTLE_CYC - 1);
  localparam logic [6:0] CheckLast  = 7'(CHECK_CYC - 1);
  localparam logic [6:0] WaitLast   = 7'(SLIP_WAIT - 1);
  localparam logic [3:0] MaxSlips   = 4'(MAX_SLIPS);
  localparam logic [5:0] MinEye     = 6'(MIN_EYE);
  localparam logic [2:0] LossLast   = 3'(LOSS_CYC - 1);

  typedef enum logic [3:0] {
    StIdle, StWaitRdy, StSettle, StCheck, StScore, StCenter,
    StSlipSettle, StSlipCheck, StSlipWait, StLocked, StError
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [4:0] delay_val_q, delay_val_d;  // doubles as the sweep tap
  logic       bitslip_q, bitslip_d;
  logic       busy_q, busy_d;
  logic       aligned_q, aligned_d;
  logic       align_err_q, align_err_d;
  logic       lock_lost_q, lock_lost_d;
  logic [4:0] eye_start_q, eye_start_d;
  logic [5:0] eye_len_q, eye_len_d;
  logic [3:0] slip_cnt_q, slip_cnt_d;
  logic [4:0] cur_start_q, cur_start_d;
  logic [5:0] cur_len_q, cur_len_d;
  logic [3:0] ref_q, ref_d;
  logic       good_q, good_d;
  logic [2:0] miss_q, miss_d;
  logic       rdy_meta_q, rdy_sync_q;
  logic [5:0] run_len;
  logic [4:0] run_start;
  logic       restart;
  logic       abort;

  // True when w is any rotation of the aligned frame word.
  function automatic logic is_rot(input logic [3:0] w);
    return (w == FRAME_PATTERN) ||
           (w == {FRAME_PATTERN[0], FRAME_PATTERN[3:1]}) ||
           (w == {FRAME_PATTERN[1:0], FRAME_PATTERN[3:2]}) ||
           (w == {FRAME_PATTERN[2:0], FRAME_PATTERN[3]});
  endfunction

  // Next-state, sweep scoring, slip sequencing and registered-output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    delay_val_d = delay_val_q;
    bitslip_d   = 1'b0;
    align_err_d = align_err_q;
    lock_lost_d = lock_lost_q;
    eye_start_d = eye_start_q;
    eye_len_d   = eye_len_q;
    slip_cnt_d  = slip_cnt_q;
    cur_start_d = cur_start_q;
    cur_len_d   = cur_len_q;
    ref_d       = ref_q;
    good_d      = good_q;
    miss_d      = miss_q;
    run_len     = cur_len_q;
    run_start   = cur_start_q;
    restart     = 1'b0;
    abort       = 1'b0;

    unique case (state_q)
      StIdle:  restart = start;
      StWaitRdy: begin
        if (rdy_sync_q) begin
          delay_val_d = 5'd0;
          cnt_d       = 7'd0;
          cur_len_d   = 6'd0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        if (!rdy_sync_q) begin
          abort = 1'b1;
        end else if (cnt_q == SettleLast) begin
          cnt_d   = 7'd0;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StCheck: begin
        if (!rdy_sync_q) begin
          abort = 1'b1;
        end else begin
          if (cnt_q == 7'd0) begin
            ref_d  = fr_in;
            good_d = is_rot(fr_in);
          end else if (fr_in != ref_q) begin
            good_d = 1'b0;
          end
          if (cnt_q == CheckLast) begin
            cnt_d   = 7'd0;
            state_d = StScore;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      StScore: begin
        if (!rdy_sync_q) begin
          abort = 1'b1;
        end else begin
          if (good_q) begin
            run_len     = cur_len_q + 6'd1;
            run_start   = (cur_len_q == 6'd0) ? delay_val_q : cur_start_q;
            cur_len_d   = run_len;
            cur_start_d = run_start;
          end else begin
            cur_len_d = 6'd0;
          end
          // A run is closed by a bad tap or by the end of the sweep; ties keep the earlier eye.
          if ((!good_q || (delay_val_q == 5'd31)) && (run_len > eye_len_q)) begin
            eye_start_d = run_start;
            eye_len_d   = run_len;
          end
          if (delay_val_q != 5'd31) begin
            delay_val_d = delay_val_q + 5'd1;
            state_d     = StSettle;
          end else begin
            state_d = StCenter;
          end
        end
      end
      StCenter: begin
        if (eye_len_q < MinEye) begin
          align_err_d = 1'b1;
          state_d     = StError;
        end else begin
          // Eye lies within 0..31, so start + len/2 never wraps.
          delay_val_d = eye_start_q + eye_len_q[5:1];
          cnt_d       = 7'd0;
          state_d     = StSlipSettle;
        end
      end
      StSlipSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = 7'd0;
          state_d = StSlipCheck;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StSlipCheck: begin
        if (fr_in == FRAME_PATTERN) begin
          miss_d  = 3'd0;
          state_d = StLocked;
        end else if (slip_cnt_q == MaxSlips) begin
          align_err_d = 1'b1;
          state_d     = StError;
        end else begin
          bitslip_d  = 1'b1;
          slip_cnt_d = slip_cnt_q + 4'd1;
          cnt_d      = 7'd0;
          state_d    = StSlipWait;
        end
      end
      StSlipWait: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = 7'd0;
          state_d = StSlipCheck;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StLocked: begin
        if (start) begin
          restart = 1'b1;
        end else if (fr_in != FRAME_PATTERN) begin
          if (miss_q == LossLast) begin
            lock_lost_d = 1'b1;
            state_d     = StIdle;
          end else begin
            miss_d = miss_q + 3'd1;
          end
        end else begin
          miss_d = 3'd0;
        end
      end
      StError: restart = start;
      default: state_d = StIdle;
    endcase

    // Loss of IDELAYCTRL ready throws away the partial sweep.
    if (abort) begin
      eye_start_d = 5'd0;
      eye_len_d   = 6'd0;
      cur_len_d   = 6'd0;
      cnt_d       = 7'd0;
      state_d     = StWaitRdy;
    end

    if (restart) begin
      align_err_d = 1'b0;
      lock_lost_d = 1'b0;
      slip_cnt_d  = 4'd0;
      eye_start_d = 5'd0;
      eye_len_d   = 6'd0;
      cur_len_d   = 6'd0;
      state_d     = StWaitRdy;
    end

    busy_d    = !((state_d == StIdle) || (state_d == StLocked) || (state_d == StError));
    aligned_d = (state_d == StLocked);
  end

  // State and output registers; reset clears everything, truncating any bitslip pulse.
  always_ff @(posedge DCO_2D or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      cnt_q       <= 7'd0;
      delay_val_q <= 5'd0;
      bitslip_q   <= 1'b0;
      busy_q      <= 1'b0;
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
      lock_lost_q <= 1'b0;
      eye_start_q <= 5'd0;
      eye_len_q   <= 6'd0;
      slip_cnt_q  <= 4'd0;
      cur_start_q <= 5'd0;
      cur_len_q   <= 6'd0;
      ref_q       <= 4'd0;
      good_q      <= 1'b0;
      miss_q      <= 3'd0;
      rdy_meta_q  <= 1'b0;
      rdy_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      delay_val_q <= delay_val_d;
      bitslip_q   <= bitslip_d;
      busy_q      <= busy_d;
      aligned_q   <= aligned_d;
      align_err_q <= align_err_d;
      lock_lost_q <= lock_lost_d;
      eye_start_q <= eye_start_d;
      eye_len_q   <= eye_len_d;
      slip_cnt_q  <= slip_cnt_d;
      cur_start_q <= cur_start_d;
      cur_len_q   <= cur_len_d;
      ref_q       <= ref_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      rdy_meta_q  <= idelay_rdy;
      rdy_sync_q  <= rdy_meta_q;
    end
  end

  assign delay_val = delay_val_q;
  assign bitslip   = bitslip_q;
  assign busy      = busy_q;
  assign aligned   = aligned_q;
  assign align_err = align_err_q;
  assign lock_lost = lock_lost_q;
  assign eye_start = eye_start_q;
  assign eye_len   = eye_len_q;
  assign slip_cnt  = slip_cnt_q;

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// Bench for adc_frame_align_ctrl: a behavioural receiver model produces fr_in
// from the tap and the observed bitslips; results are compared with an eye/slip model.
module tb_adc_frame_align_ctrl;

  localparam int SLIP_WAIT = 8;
  localparam int MAX_SLIPS = 8;
  localparam int MIN_EYE   = 4;

  logic       DCO_2D;
  logic       rst_n_in;
  logic       start;
  logic       idelay_rdy;
  logic [3:0] fr_in;
  logic [4:0] delay_val;
  logic       bitslip;
  logic       busy;
  logic       aligned;
  logic       align_err;
  logic       lock_lost;
  logic [4:0] eye_start;
  logic [5:0] eye_len;
  logic [3:0] slip_cnt;

  adc_frame_align_ctrl dut (
    .DCO_2D     (DCO_2D),
    .rst_n_in   (rst_n_in),
    .start      (start),
    .idelay_rdy (idelay_rdy),
    .fr_in      (fr_in),
    .delay_val  (delay_val),
    .bitslip    (bitslip),
    .busy       (busy),
    .aligned    (aligned),
    .align_err  (align_err),
    .lock_lost  (lock_lost),
    .eye_start  (eye_start),
    .eye_len    (eye_len),
    .slip_cnt   (slip_cnt)
  );

  initial begin
    DCO_2D = 1'b0;
    forever #5 DCO_2D = ~DCO_2D;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Receiver model state.
  bit         tap_good [32];
  logic [3:0] rx_base     = 4'b0011;
  bit         rx_slip_eff = 1'b1;
  int         slips       = 0;
  int         pulses      = 0;
  int         last_pulse  = -1;
  int         cyc         = 0;
  int         force_bad   = 0;
  bit         prev_bs     = 1'b0;
  bit         tog         = 1'b0;

  function automatic logic [3:0] rotr(input logic [3:0] w, input int n);
    logic [3:0] r = w;
    for (int k = 0; k < n; k++) r = {r[0], r[3:1]};
    return r;
  endfunction

  // Receiver: bitslip rotates the word; good taps give a steady word, bad ones toggle.
  initial begin
    fr_in = 4'b0000;
    forever begin
      @(negedge DCO_2D);
      if (bitslip) begin
        check_eq("bitslip_width", {31'd0, prev_bs}, 0);
        if (last_pulse >= 0) check_eq("bitslip_gap", ((cyc - last_pulse - 1) >= SLIP_WAIT), 1);
        last_pulse = cyc;
        pulses++;
        slips++;
      end
      prev_bs = bitslip;
      cyc++;
      tog = ~tog;
      if (force_bad > 0) begin
        fr_in = 4'b0101;
        force_bad--;
      end else if (tap_good[delay_val]) begin
        fr_in = rotr(rx_base, rx_slip_eff ? (slips % 4) : 0);
      end else begin
        fr_in = tog ? rx_base : ~rx_base;
      end
    end
  end

  task automatic set_taps(input int lo0, input int hi0, input int lo1, input int hi1);
    for (int t = 0; t < 32; t++)
      tap_good[t] = ((t >= lo0) && (t <= hi0)) || ((t >= lo1) && (t <= hi1));
  endtask

  // Widest maximal run of good taps; the first one wins ties.
  task automatic model_eye(output int es, output int el);
    es = 0;
    el = 0;
    for (int s = 0; s < 32; s++) begin
      if (tap_good[s] && (s == 0 || !tap_good[s-1])) begin
        int len = 0;
        while ((s + len) < 32 && tap_good[s+len]) len++;
        if (len > el) begin
          es = s;
          el = len;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge DCO_2D); #1;
    slips      = 0;
    pulses     = 0;
    last_pulse = -1;
    start      = 1'b1;
    @(negedge DCO_2D); #1;
    start = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [3:0] base, input bit slip_eff,
                          input int abort_tap);
    int es, el, exp_slips, exp_dv;
    bit exp_err, done, aborted;
    model_eye(es, el);
    exp_err   = (el < MIN_EYE);
    exp_slips = -1;
    for (int k = 0; k <= MAX_SLIPS; k++)
      if (exp_slips < 0 && rotr(base, slip_eff ? k : 0) == 4'b0011) exp_slips = k;
    exp_dv = exp_err ? 31 : es + el / 2;
    rx_base     = base;
    rx_slip_eff = slip_eff;
    pulse_start();
    check_eq({tag, "_busy"}, {31'd0, busy}, 1);
    done    = 0;
    aborted = 0;
    for (int i = 0; i < 12000 && !done; i++) begin
      @(negedge DCO_2D); #1;
      if (!aborted && abort_tap >= 0 && i > 20 && delay_val == 5'(abort_tap)) begin
        aborted    = 1;
        idelay_rdy = 1'b0;
        repeat (10) @(negedge DCO_2D);
        #1 idelay_rdy = 1'b1;
      end
      if (!busy) done = 1;
    end
    check_eq({tag, "_done"}, {31'd0, done}, 1);
    check_eq({tag, "_eye_start"}, {27'd0, eye_start}, es);
    check_eq({tag, "_eye_len"}, {26'd0, eye_len}, el);
    check_eq({tag, "_delay_val"}, {27'd0, delay_val}, exp_dv);
    if (exp_err) begin
      check_eq({tag, "_align_err"}, {31'd0, align_err}, 1);
      check_eq({tag, "_slip_cnt"}, {28'd0, slip_cnt}, 0);
      check_eq({tag, "_pulses"}, pulses, 0);
    end else if (exp_slips < 0) begin
      check_eq({tag, "_align_err"}, {31'd0, align_err}, 1);
      check_eq({tag, "_slip_cnt"}, {28'd0, slip_cnt}, MAX_SLIPS);
      check_eq({tag, "_pulses"}, pulses, MAX_SLIPS);
    end else begin
      check_eq({tag, "_aligned"}, {31'd0, aligned}, 1);
      check_eq({tag, "_slip_cnt"}, {28'd0, slip_cnt}, exp_slips);
      check_eq({tag, "_pulses"}, pulses, exp_slips);
    end
  endtask

  initial begin
    int t_hit;
    rst_n_in   = 1'b0;
    start      = 1'b0;
    idelay_rdy = 1'b1;
    set_taps(0, 31, -1, -2);
    repeat (3) @(negedge DCO_2D);
    check_eq("rst_delay_val", {27'd0, delay_val}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_aligned", {31'd0, aligned}, 0);
    check_eq("rst_bitslip", {31'd0, bitslip}, 0);
    check_eq("rst_eye_len", {26'd0, eye_len}, 0);
    rst_n_in = 1'b1;
    repeat (3) @(negedge DCO_2D);

    // Wide eye, then lock monitoring.
    set_taps(0, 31, -1, -2);
    run_case("wide", 4'b0110, 1'b1, -1);
    @(negedge DCO_2D); #1 force_bad = 3;
    repeat (12) @(negedge DCO_2D);
    check_eq("loss3_aligned", {31'd0, aligned}, 1);
    check_eq("loss3_lock_lost", {31'd0, lock_lost}, 0);
    #1 force_bad = 4;
    repeat (12) @(negedge DCO_2D);
    check_eq("loss4_aligned", {31'd0, aligned}, 0);
    check_eq("loss4_lock_lost", {31'd0, lock_lost}, 1);
    check_eq("loss4_busy", {31'd0, busy}, 0);
    check_eq("loss4_delay_val", {27'd0, delay_val}, 16);

    set_taps(10, 19, -1, -2);
    run_case("offset", 4'b0011, 1'b1, -1);
    check_eq("offset_lock_lost_cleared", {31'd0, lock_lost}, 0);
    set_taps(2, 5, 20, 23);
    run_case("tie", 4'b1001, 1'b1, -1);
    set_taps(7, 9, -1, -2);
    run_case("narrow", 4'b0011, 1'b1, -1);
    set_taps(0, 31, -1, -2);
    run_case("slipfail", 4'b0110, 1'b0, -1);
    set_taps(10, 19, -1, -2);
    run_case("rdy_abort", 4'b1100, 1'b1, 5);

    // Asynchronous reset mid-sweep.
    set_taps(0, 31, -1, -2);
    pulse_start();
    t_hit = 0;
    for (int i = 0; i < 3000 && t_hit == 0; i++) begin
      @(negedge DCO_2D);
      if (delay_val == 5'd12) t_hit = 1;
    end
    check_eq("areset_reached_tap12", t_hit, 1);
    repeat (20) @(negedge DCO_2D);
    #2 rst_n_in = 1'b0;
    #1;
    check_eq("areset_delay_val", {27'd0, delay_val}, 0);
    check_eq("areset_busy", {31'd0, busy}, 0);
    check_eq("areset_eye_len", {26'd0, eye_len}, 0);
    check_eq("areset_eye_start", {27'd0, eye_start}, 0);
    check_eq("areset_flags", {28'd0, bitslip, aligned, align_err, lock_lost}, 0);
    @(negedge DCO_2D);
    rst_n_in = 1'b1;
    repeat (3) @(negedge DCO_2D);

    // Random tap maps and frame rotations.
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 32; t++) tap_good[t] = ($urandom_range(3) != 0);
      run_case($sformatf("rand%0d", r), rotr(4'b0011, int'($urandom_range(3))),
               ($urandom_range(4) != 0), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
